// File: rtl/controller_pio_pkg.sv
// Shared register map and default widths for the controller's output PIO.
package controller_pio_pkg;

    localparam int PIO_DATA_W  = 32;
    localparam int PIO_PULSE_W = 16;
    localparam int PIO_ADDR_W  = 3;

    localparam logic [PIO_ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [PIO_ADDR_W-1:0] ADDR_PULSE    = 3'd2;
    localparam logic [PIO_ADDR_W-1:0] ADDR_PLEN     = 3'd3;
    localparam logic [PIO_ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [PIO_ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [PIO_ADDR_W-1:0] ADDR_COUNT    = 3'd6;

endpackage

// File: rtl/controller_pio_pulse_timer.sv
// One-shot pulse down-counter: reloads on load, flags expiry on its last cycle.
module controller_pio_pulse_timer
    import controller_pio_pkg::*;
#(
    parameter int PULSE_W = PIO_PULSE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PULSE_W-1:0] len,
    output logic               expire,
    output logic               busy,
    output logic [PULSE_W-1:0] count
);

    logic [PULSE_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len;
        end else if (cnt != '0) begin
            cnt <= cnt - PULSE_W'(1);
        end
    end

    // Expiry is the final counted cycle; the owner clears its pulse bits on this edge.
    assign expire = (cnt == PULSE_W'(1));
    assign busy   = (cnt != '0);
    assign count  = cnt;

endmodule

// File: rtl/controller_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and hardware-timed one-shot pulses.
module controller_pio_out_pulse
    import controller_pio_pkg::*;
#(
    parameter int                DATA_W      = PIO_DATA_W,
    parameter int                PULSE_W     = PIO_PULSE_W,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIO_ADDR_W-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic [DATA_W-1:0]     out_port,
    output logic                  pulse_busy
);

    logic [DATA_W-1:0]  out_q;
    logic [DATA_W-1:0]  pmask_q;
    logic [PULSE_W-1:0] plen_q;
    logic [DATA_W-1:0]  out_nxt;
    logic [DATA_W-1:0]  pmask_nxt;
    logic [DATA_W-1:0]  rd_nxt;
    logic               wr_en;
    logic               pulse_load;
    logic               expire;
    logic               busy;
    logic [PULSE_W-1:0] count;

    assign wr_en      = chipselect && !write_n;
    assign pulse_load = wr_en && (address == ADDR_PULSE) && (plen_q != '0);

    controller_pio_pulse_timer #(
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (pulse_load),
        .len    (plen_q),
        .expire (expire),
        .busy   (busy),
        .count  (count)
    );

    // Expiry clear is resolved first so a coincident CPU write lands on top of it.
    always_comb begin
        out_nxt   = out_q;
        pmask_nxt = pmask_q;
        if (expire) begin
            out_nxt   = out_q & ~pmask_q;
            pmask_nxt = '0;
        end
        if (wr_en) begin
            case (address)
                ADDR_DATA: out_nxt = writedata;
                ADDR_PULSE: begin
                    if (plen_q != '0) begin
                        out_nxt   = out_nxt | writedata;
                        pmask_nxt = pmask_nxt | writedata;
                    end
                end
                ADDR_OUTSET: out_nxt = out_nxt | writedata;
                ADDR_OUTCLEAR: begin
                    out_nxt   = out_nxt & ~writedata;
                    pmask_nxt = pmask_nxt & ~writedata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_DATA:  rd_nxt = out_q;
            ADDR_PULSE: rd_nxt = pmask_q;
            ADDR_PLEN:  rd_nxt = {{(DATA_W-PULSE_W){1'b0}}, plen_q};
            ADDR_COUNT: rd_nxt = {{(DATA_W-PULSE_W){1'b0}}, count};
            default:    rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= RESET_VALUE;
            pmask_q  <= '0;
            plen_q   <= '0;
            readdata <= '0;
        end else begin
            out_q    <= out_nxt;
            pmask_q  <= pmask_nxt;
            readdata <= rd_nxt;
            if (wr_en && (address == ADDR_PLEN)) begin
                plen_q <= writedata[PULSE_W-1:0];
            end
        end
    end

    assign out_port   = out_q;
    assign pulse_busy = busy;

endmodule

// File: doc/controller_pio_out_pulse.md
Name: controller_pio_out_pulse

Overview:
- Avalon-MM slave output PIO: the CPU-writable counterpart of the design's read-only input PIOs.
- Drives a 32-bit out_port from a register.
- Supports atomic bit set and bit clear.
- Supports hardware-timed one-shot pulses: selected bits go high for a programmed number of clocks, then clear themselves.
- Sits on the controller's Avalon interconnect next to the input PIOs and drives FPGA control strobes and enables.

Parameters:
- DATA_W, 32, width of out_port, writedata and readdata.
- PULSE_W, 16, width of the pulse-length register and the down-counter.
- RESET_VALUE, 0, reset value of the output register.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  registered read data
- out_port  out  DATA_W  output register
- pulse_busy  out  1  high while the pulse counter is non-zero

Behaviour:
- Reset (asynchronous, active-high):
  - out=RESET_VALUE, pmask=0, plen=0, cnt=0, readdata=0, pulse_busy=0.
- Register map (word address):
  - 0 DATA (R/W): write sets out=writedata.
  - 2 PULSE (W; reads return pmask): start a pulse.
  - 3 PLEN (R/W): low PULSE_W bits of writedata; reads zero-extend.
  - 4 OUTSET (W): out |= writedata.
  - 5 OUTCLEAR (W): out &= ~writedata and pmask &= ~writedata.
  - 6 COUNT (R): cnt, zero-extended.
  - 1, 7: read 0; writes ignored.
- Reads:
  - readdata is updated on every clock edge from address, regardless of chipselect.
  - Read latency is 1 cycle.
  - Reading has no side effects.
- Pulse start (write to PULSE with plen=L):
  - L=0: write ignored; no register changes.
  - L>0: out |= wd, pmask <= (restart ? wd : pmask|wd), cnt <= L.
  - restart = 1 if the expiry condition holds in the same cycle.
- Countdown and expiry:
  - While cnt>0, cnt decrements by 1 each cycle.
  - Expiry is the cycle with cnt==1: cnt <= 0, out &= ~pmask, pmask <= 0.
  - Result: pulse bits are high on out_port for exactly L clocks, starting the cycle after the write edge.
- Retrigger: a PULSE write while cnt>0 reloads cnt to L and ORs the new bits into pmask, so all pending bits extend to the new deadline.
- Same-cycle priority: the expiry clear is applied first, then any CPU write is applied on top.
  - DATA write coincident with expiry: out = writedata exactly.
  - OUTSET coincident with expiry: bits in writedata stay set.
- DATA write during a pulse: pmask and cnt are untouched; expiry still clears the pmask bits.
- PLEN write during a pulse: does not affect the running cnt; applies to the next PULSE write.
- OUTCLEAR covering all pmask bits: pmask=0, but cnt keeps running to 0 (expiry then has no effect).
- pulse_busy is combinational: (cnt != 0).
- Bus timing: no wait states; one write per cycle accepted.

Decomposition:
- Shared package controller_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_PULSE=2, ADDR_PLEN=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5, ADDR_COUNT=6;
  - the default widths.
- One natural sub-module, controller_pio_pulse_timer:
  - contains cnt, the load/decrement logic and expiry generation;
  - inputs: load, len; outputs: expire, busy, count.
- The top level keeps out, pmask, plen and the read mux.

Test Plan:
- Reset mid-pulse: assert reset while cnt=5 -> out_port, readdata, pulse_busy and COUNT all 0 immediately; after release, COUNT reads 0.
- DATA then OUTSET then OUTCLEAR: write DATA=0x0000_00F0, OUTSET=0x0000_0003, OUTCLEAR=0x0000_0010 -> out_port=0x0000_00E3; a read of address 0 returns 0x0000_00E3 one cycle after address is presented.
- Basic pulse: PLEN=4, PULSE=0x0000_0100 -> bit 8 high for exactly 4 clocks then low; pulse_busy high for the same 4 cycles; PULSE reads 0 afterwards.
- Zero length: PLEN=0, PULSE=0xFFFF_FFFF -> out_port unchanged; pulse_busy stays 0.
- Retrigger plus coincident write:
  - PLEN=3, PULSE=0x1; two cycles later PULSE=0x2 -> both bits clear together 3 cycles after the second write.
  - Separately, OUTSET=0x1 in the expiry cycle -> bit 0 remains 1.
- Undefined address: write 0xDEAD_BEEF to address 7 -> no register changes; reads of addresses 1 and 7 return 0.
